// File: rtl/hwag_out_sched_pkg.sv
// Shared types and helpers for the angle-scheduled output generator.
// Optional dwell limit is enabled with HWAG_OUT_DWELL_LIMIT_EN.
package hwag_pkg;

    localparam int HWAG_ANGLE_TOP = 3839;
    localparam int HWAG_CYC_LEN   = 2 * (HWAG_ANGLE_TOP + 1);

    typedef enum logic [1:0] {
        CH_IDLE  = 2'd0,
        CH_ARMED = 2'd1,
        CH_ON    = 2'd2
    } ch_state_t;

    // True when target t lies in (p, c], wrapping through 0 when c < p.
    // Without a valid previous angle only an exact hit counts.
    function automatic logic cross_chk(input logic [31:0] p,
                                       input logic [31:0] c,
                                       input logic [31:0] t,
                                       input logic        valid);
        if (!valid)
            return (c == t);
        if (c > p)
            return (t > p) && (t <= c);
        if (c < p)
            return (t > p) || (t <= c);
        return 1'b0;
    endfunction

endpackage

// File: rtl/hwag_out_channel.sv
// One output channel: shadow/active angle registers, IDLE/ARMED/ON FSM and,
// with HWAG_OUT_DWELL_LIMIT_EN, a dwell-time limiter with sticky fault.
module hwag_out_channel
    import hwag_pkg::*;
#(
    parameter int CYC_WIDTH = 25
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    ,
    parameter int DWELL_WIDTH = 20
`endif
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_hwag_start,
    input  logic                   i_step,
    input  logic                   i_prev_valid,
    input  logic [CYC_WIDTH-1:0]   i_p,
    input  logic [CYC_WIDTH-1:0]   i_c,
    input  logic                   i_commit,
    input  logic                   i_we,
    input  logic [CYC_WIDTH-1:0]   i_cfg_set,
    input  logic [CYC_WIDTH-1:0]   i_cfg_reset,
    input  logic                   i_cfg_ena,
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    input  logic [DWELL_WIDTH-1:0] i_dwell_max,
    output logic                   o_fault,
`endif
    output logic                   o_out,
    output logic                   o_pending
);

    logic [CYC_WIDTH-1:0] r_sh_set, r_sh_rst, r_set, r_rst;
    logic                 r_sh_ena, r_ena, r_pend, r_out;
    ch_state_t            r_state, w_nxt;
    logic                 w_set_x, w_rst_x;

`ifdef HWAG_OUT_DWELL_LIMIT_EN
    logic [DWELL_WIDTH-1:0] r_dwell;
    logic [DWELL_WIDTH:0]   w_dw_inc;
    logic                   w_dwell_hit;
    logic                   r_fault;

    assign w_dw_inc    = {1'b0, r_dwell} + {{DWELL_WIDTH{1'b0}}, 1'b1};
    assign w_dwell_hit = (r_state == CH_ON) && (w_dw_inc >= {1'b0, i_dwell_max});
    assign o_fault     = r_fault;
`endif

    // Shadow takes writes; active is refreshed from shadow on commit.
    // A write on a commit clock lands in shadow and stays pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sh_set <= '0;
            r_sh_rst <= '0;
            r_sh_ena <= 1'b0;
            r_set    <= '0;
            r_rst    <= '0;
            r_ena    <= 1'b0;
            r_pend   <= 1'b0;
        end else begin
            if (i_commit) begin
                r_set <= r_sh_set;
                r_rst <= r_sh_rst;
                r_ena <= r_sh_ena;
            end
            if (i_we) begin
                r_sh_set <= i_cfg_set;
                r_sh_rst <= i_cfg_reset;
                r_sh_ena <= i_cfg_ena;
                r_pend   <= 1'b1;
            end else if (i_commit) begin
                r_pend   <= 1'b0;
            end
        end
    end

    always_comb begin
        w_set_x = cross_chk(32'(i_p), 32'(i_c), 32'(r_set), i_prev_valid);
        w_rst_x = cross_chk(32'(i_p), 32'(i_c), 32'(r_rst), i_prev_valid);
        w_nxt   = r_state;
        case (r_state)
            CH_IDLE:  if (i_hwag_start && r_ena) w_nxt = CH_ARMED;
            // A simultaneous reset crossing suppresses the pulse
            CH_ARMED: if (i_step && w_set_x && !w_rst_x) w_nxt = CH_ON;
            CH_ON: begin
                if (i_step && w_rst_x)
                    w_nxt = CH_ARMED;
`ifdef HWAG_OUT_DWELL_LIMIT_EN
                else if (w_dwell_hit)
                    w_nxt = CH_ARMED;
`endif
            end
            default:  w_nxt = CH_IDLE;
        endcase
        if (!i_hwag_start || !r_ena)
            w_nxt = CH_IDLE;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= CH_IDLE;
            r_out   <= 1'b0;
        end else begin
            r_state <= w_nxt;
            r_out   <= (w_nxt == CH_ON);
        end
    end

`ifdef HWAG_OUT_DWELL_LIMIT_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_dwell <= '0;
            r_fault <= 1'b0;
        end else begin
            r_dwell <= (r_state == CH_ON && w_nxt == CH_ON) ? w_dw_inc[DWELL_WIDTH-1:0] : '0;
            if (w_dwell_hit && i_hwag_start && r_ena)
                r_fault <= 1'b1;
            else if (i_we)
                r_fault <= 1'b0;
        end
    end
`endif

    assign o_out     = r_out;
    assign o_pending = r_pend;

endmodule

// File: rtl/hwag_out_sched.sv
// Angle-scheduled N-channel output generator: cycle-angle tracking, wrap
// detect, config decode. Optional dwell limit: HWAG_OUT_DWELL_LIMIT_EN.
module hwag_out_sched
    import hwag_pkg::*;
#(
    parameter int CH_NUM       = 4,
    parameter int ANGLE_WIDTH  = 24,
    parameter int ANGLE_TOP    = HWAG_ANGLE_TOP,
    parameter int CYC_WIDTH    = 25,
    parameter int CH_IDX_WIDTH = 2
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    ,
    parameter int DWELL_WIDTH  = 20
`endif
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    hwag_start,
    input  logic [ANGLE_WIDTH-1:0]  angle,
    input  logic                    angle_step,
    input  logic                    cam_phase,
    input  logic                    cfg_we,
    input  logic [CH_IDX_WIDTH-1:0] cfg_ch,
    input  logic [CYC_WIDTH-1:0]    cfg_set,
    input  logic [CYC_WIDTH-1:0]    cfg_reset,
    input  logic                    cfg_ena,
`ifdef HWAG_OUT_DWELL_LIMIT_EN
    input  logic [DWELL_WIDTH-1:0]  dwell_max,
    output logic [CH_NUM-1:0]       dwell_fault,
`endif
    output logic [CH_NUM-1:0]       out,
    output logic [CYC_WIDTH-1:0]    cyc_angle,
    output logic [CH_NUM-1:0]       cfg_pending
);

    logic [ANGLE_WIDTH-1:0] w_ang;
    logic [CYC_WIDTH-1:0]   w_c, r_cyc;
    logic                   r_pv, w_step, w_wrap, w_commit;
    logic [CH_NUM-1:0]      w_we;

    assign w_ang  = (angle > ANGLE_WIDTH'(ANGLE_TOP)) ? ANGLE_WIDTH'(ANGLE_TOP) : angle;
    assign w_c    = cam_phase ? (CYC_WIDTH'(w_ang) + CYC_WIDTH'(ANGLE_TOP + 1)) : CYC_WIDTH'(w_ang);
    assign w_step = angle_step && hwag_start;
    // Backwards motion of the cycle angle marks the 720 degree boundary
    assign w_wrap   = w_step && r_pv && (w_c < r_cyc);
    assign w_commit = !hwag_start || w_wrap;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cyc <= '0;
            r_pv  <= 1'b0;
        end else begin
            if (w_step)
                r_cyc <= w_c;
            if (!hwag_start)
                r_pv <= 1'b0;
            else if (w_step)
                r_pv <= 1'b1;
        end
    end

    for (genvar g = 0; g < CH_NUM; g++) begin : g_ch
        assign w_we[g] = cfg_we && (int'(cfg_ch) == g);

        hwag_out_channel #(
            .CYC_WIDTH   (CYC_WIDTH)
`ifdef HWAG_OUT_DWELL_LIMIT_EN
            ,
            .DWELL_WIDTH (DWELL_WIDTH)
`endif
        ) u_ch (
            .clk          (clk),
            .rst          (rst),
            .i_hwag_start (hwag_start),
            .i_step       (w_step),
            .i_prev_valid (r_pv),
            .i_p          (r_cyc),
            .i_c          (w_c),
            .i_commit     (w_commit),
            .i_we         (w_we[g]),
            .i_cfg_set    (cfg_set),
            .i_cfg_reset  (cfg_reset),
            .i_cfg_ena    (cfg_ena),
`ifdef HWAG_OUT_DWELL_LIMIT_EN
            .i_dwell_max  (dwell_max),
            .o_fault      (dwell_fault[g]),
`endif
            .o_out        (out[g]),
            .o_pending    (cfg_pending[g])
        );
    end

    assign cyc_angle = r_cyc;

endmodule

// File: doc/hwag_out_sched.md
Name: hwag_out_sched

Overview:
- N-channel angle-scheduled output generator for ignition/injection.
- Driven by the angle generator's angle counter (0..ANGLE_TOP per revolution) plus the cam phase bit. Forms a 720° cycle angle and drives each output high/low at programmable set/reset angles.
- Generalises the fixed 4-channel ignition comparators:
  - parametrised channel count and widths;
  - runtime-programmable double-buffered angles;
  - crossing detection tolerant of angle jumps;
  - per-channel enable.

Parameters:
- CH_NUM, 4, number of output channels
- ANGLE_WIDTH, 24, width of revolution angle input
- ANGLE_TOP, 3839, last angle tick of one revolution (60 teeth x 64)
- CYC_WIDTH, 25, width of 720° cycle angle (holds 2*(ANGLE_TOP+1)-1)
- CH_IDX_WIDTH, 2, width of channel index on config bus

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- hwag_start  in  1  angle generator synchronised
- angle  in  ANGLE_WIDTH  current revolution angle (acnt)
- angle_step  in  1  one-clk strobe: angle has a new value this cycle
- cam_phase  in  1  revolution select (0 = first, 1 = second 360°)
- cfg_we  in  1  config write strobe
- cfg_ch  in  CH_IDX_WIDTH  target channel
- cfg_set  in  CYC_WIDTH  set angle (cycle space)
- cfg_reset  in  CYC_WIDTH  reset angle (cycle space)
- cfg_ena  in  1  channel enable
- out  out  CH_NUM  channel outputs
- cyc_angle  out  CYC_WIDTH  registered cycle angle
- cfg_pending  out  CH_NUM  shadow written, not yet committed

Behaviour:
- Reset (rst=0):
  - out=0, cyc_angle=0, cfg_pending=0;
  - all active/shadow set/reset=0, ena=0;
  - prev_valid=0; all channels IDLE.
- Cycle angle:
  - c = cam_phase ? angle+ANGLE_TOP+1 : angle;
  - registered into cyc_angle on angle_step with hwag_start=1.
- Crossing of target t, previous p, current c:
  - c>p: p<t<=c;
  - c<p (wrap): t>p or t<=c;
  - c==p: no event;
  - prev_valid=0: only c==t.
- Per-channel FSM:
  - IDLE→ARMED when hwag_start=1 and ena=1.
  - ARMED→ON on set crossing.
  - ON→ARMED on reset crossing.
  - Any state→IDLE on hwag_start=0 or ena=0.
  - out=1 only in ON.
  - Transitions occur on the edge sampling angle_step; out is visible 1 clk later.
- Simultaneous events:
  - Set and reset crossings in the same step: if ARMED, stay ARMED (pulse suppressed); if ON, go ARMED.
  - set==reset: channel never asserts.
- Config:
  - cfg_we writes the shadow of cfg_ch and sets cfg_pending[cfg_ch].
  - cfg_ch>=CH_NUM is ignored.
  - Commit shadow→active when:
    - hwag_start=0 (every clk), or
    - the step where c<p (720° wrap).
  - The wrap step's own crossing evaluation uses the old active values.
  - Commit clears cfg_pending.
  - cfg_we on the same clk as commit: the new write wins and stays pending.
- hwag_start falling:
  - next clk: out=0, all channels IDLE, prev_valid=0.
  - cyc_angle holds its value.
- angle_step while hwag_start=0 is ignored.
- Angle out of range (angle>ANGLE_TOP) is clamped to ANGLE_TOP.

Optional Feature:
- Macro: HWAG_OUT_DWELL_LIMIT_EN.
- With macro:
  - adds parameter DWELL_WIDTH (default 20) and input dwell_max[DWELL_WIDTH-1:0];
  - per-channel clk counter runs while ON and clears on leaving ON;
  - when it reaches dwell_max, the channel goes ARMED (out=0 next clk) and sets a sticky dwell_fault[CH_NUM] output bit;
  - the bit clears on cfg_we to that channel.
- Without macro: no counters, no dwell ports; ON exits only on reset crossing or IDLE conditions.

Decomposition:
- Package hwag_pkg:
  - ANGLE_TOP, cycle length constant;
  - ch_state_t enum {CH_IDLE, CH_ARMED, CH_ON};
  - crossing function (p, c, t, valid).
- Sub-module hwag_out_channel: one channel's shadow/active registers, FSM and optional dwell counter; generated CH_NUM times.
- Top level holds the cycle-angle register, prev_valid, wrap detect and config decode.

Test Plan:
- Reset, program ch0 set=128 reset=0 ena=1, hwag_start=1, step angle 0..3839 phase 0 then phase 1 → out[0] rises 1 clk after step at c=128; falls after wrap step c=0; out[1..3]=0.
- Angle jump: ch1 set=1000 reset=1200; steps 990 then 1100 → out[1] rises after the 1100 step (crossed); step 1250 → falls.
- Wrap window: ch2 set=7600 reset=64; steps 7590→7610 → on; 7679→0 → stays on; →70 → off.
- Shadow commit: mid-cycle write ch0 set=256 → cfg_pending[0]=1, old set=128 still fires; after wrap the pulse starts at 256 and cfg_pending[0]=0.
- hwag_start dropped while out[0]=1 → out=0 next clk; re-sync with first step c=500 (set=128) → no spurious rise (prev_valid=0).
- HWAG_OUT_DWELL_LIMIT_EN: dwell_max=50, ON held → out falls at clk 50 of ON, dwell_fault[0]=1; cfg_we ch0 → cleared.
